// File: rtl/multiword_add_seq.sv
// Sequential multi-precision adder: one N-bit ripple-carry slice per clock,
// least significant slice first, with valid/ready handshakes on both sides.
module multiword_add_seq #(
    parameter int N = 8,
    parameter int K = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*K-1:0] a,
    input  logic [N*K-1:0] b,
    input  logic           cin,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*K-1:0] sum,
    output logic           carry,
    output logic           busy
);
    localparam int W  = N * K;
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic            carry_reg;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;

    logic [N-1:0]    op_a;
    logic [N-1:0]    op_b;
    logic [N:0]      ripple;
    logic [N-1:0]    slice_sum;
    logic            slice_carry;
    logic            last_slice;

    // N-bit ripple-carry stage fed from the current slice of the latched operands
    always_comb begin
        op_a      = a_reg[int'(idx)*N +: N];
        op_b      = b_reg[int'(idx)*N +: N];
        ripple    = '0;
        slice_sum = '0;
        ripple[0] = carry_reg;
        for (int i = 0; i < N; i++) begin
            slice_sum[i]  = op_a[i] ^ op_b[i] ^ ripple[i];
            ripple[i+1]   = (op_a[i] & op_b[i]) | (ripple[i] & (op_a[i] ^ op_b[i]));
        end
        slice_carry = ripple[N];
    end

    assign last_slice = (idx == IW'(K - 1));
    assign in_ready   = (state == IDLE);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum       <= '0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        idx       <= '0;
                        state     <= ADD;
                    end
                end
                ADD: begin
                    sum[int'(idx)*N +: N] <= slice_sum;
                    carry_reg             <= slice_carry;
                    if (last_slice) begin
                        carry     <= slice_carry;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    // result stays put until downstream takes it; no bypass back into ADD
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed, table-driven bench for multiword_add_seq (N=8,K=4) plus a K=1 build.
module tb_multiword_add_seq;
    localparam int N = 8;
    localparam int K = 4;
    localparam int W = N * K;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, out_ready, cin;
    logic [W-1:0]  a, b;
    logic          in_ready, out_valid, carry, busy;
    logic [W-1:0]  sum;

    logic          k1_in_valid, k1_out_ready, k1_cin;
    logic [7:0]    k1_a, k1_b, k1_sum;
    logic          k1_in_ready, k1_out_valid, k1_carry, k1_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multiword_add_seq #(.N(N), .K(K)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry(carry), .busy(busy)
    );

    multiword_add_seq #(.N(8), .K(1)) dut_k1 (
        .clk(clk), .rst(rst), .in_valid(k1_in_valid), .in_ready(k1_in_ready),
        .a(k1_a), .b(k1_b), .cin(k1_cin), .out_valid(k1_out_valid),
        .out_ready(k1_out_ready), .sum(k1_sum), .carry(k1_carry), .busy(k1_busy)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_carry;
    } vec_t;

    vec_t vecs[7];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // accept one operand set, wait (bounded) for the result, then complete the output handshake
    task automatic apply_stimulus(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                                  output logic [W-1:0] rs, output logic rc, output int lat);
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        rs = sum;
        rc = carry;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [W-1:0] rs;
    logic         rc;
    int           lat;
    logic [W-1:0] held_sum;
    logic         held_carry;
    int           acc_cyc[2];
    int           n_acc, n_res;
    logic [W-1:0] res_sum[2];
    logic         res_carry[2];
    logic         saw_valid;

    initial begin
        vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
        vecs[1] = '{32'h12345678, 32'h0F0F0F0F, 1'b1, 32'h21436588, 1'b0};
        vecs[2] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
        vecs[3] = '{32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0};
        vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[5] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0};
        vecs[6] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0};

        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; a = '1; b = '1; cin = 1'b1;
        k1_in_valid = 1'b0; k1_out_ready = 1'b0; k1_a = '0; k1_b = '0; k1_cin = 1'b0;
        tick(); tick();
        check_output("reset_out_valid", 64'(out_valid), 64'd0);
        check_output("reset_busy", 64'(busy), 64'd0);
        check_output("reset_in_ready", 64'(in_ready), 64'd1);
        check_output("reset_sum", 64'(sum), 64'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].cin, rs, rc, lat);
            check_output($sformatf("vec%0d_latency", i), 64'(lat), 64'(K));
            check_output($sformatf("vec%0d_sum", i), 64'(rs), 64'(vecs[i].exp_sum));
            check_output($sformatf("vec%0d_carry", i), 64'(rc), 64'(vecs[i].exp_carry));
            check_output($sformatf("vec%0d_idle", i), 64'(in_ready), 64'd1);
        end

        // stall in DONE with junk on the input side, then release
        a = 32'h12345678; b = 32'h0F0F0F0F; cin = 1'b1; in_valid = 1'b1;
        tick();
        a = 32'hDEADBEEF; b = 32'hCAFEF00D; cin = 1'b0;
        for (int i = 0; i < K; i++) tick();
        check_output("stall_valid_at_T+K", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check_output("stall_valid", 64'(out_valid), 64'd1);
            check_output("stall_sum", 64'(sum), 64'h21436588);
            check_output("stall_carry", 64'(carry), 64'd0);
            check_output("stall_in_ready", 64'(in_ready), 64'd0);
            if (i == 4) in_valid = 1'b0;
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_output("release_valid", 64'(out_valid), 64'd0);
        check_output("release_in_ready", 64'(in_ready), 64'd1);
        check_output("retain_sum", 64'(sum), 64'h21436588);

        // asynchronous reset mid-cycle clears the retained result immediately
        #3 rst = 1'b1;
        #1;
        check_output("async_rst_sum", 64'(sum), 64'd0);
        check_output("async_rst_carry", 64'(carry), 64'd0);
        check_output("async_rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        tick();
        check_output("post_rst_in_ready", 64'(in_ready), 64'd1);

        // back-to-back with both handshakes held high
        a = 32'h80000000; b = 32'h80000000; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        n_acc = 0; n_res = 0;
        for (int cyc = 0; cyc < 40 && n_res < 2; cyc++) begin
            logic fire_in, fire_out;
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) begin
                res_sum[n_res]   = sum;
                res_carry[n_res] = carry;
            end
            tick();
            if (fire_in) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                if (n_acc == 1) begin
                    a = 32'h00000001; b = 32'h00000002;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (fire_out) n_res++;
        end
        out_ready = 1'b0; in_valid = 1'b0;
        check_output("b2b_results", 64'(n_res), 64'd2);
        check_output("b2b_accepts", 64'(n_acc), 64'd2);
        if (n_acc == 2) check_output("b2b_spacing", 64'(acc_cyc[1] - acc_cyc[0]), 64'(K + 2));
        if (n_res == 2) begin
            check_output("b2b_sum0", 64'(res_sum[0]), 64'd0);
            check_output("b2b_carry0", 64'(res_carry[0]), 64'd1);
            check_output("b2b_sum1", 64'(res_sum[1]), 64'h3);
            check_output("b2b_carry1", 64'(res_carry[1]), 64'd0);
        end

        // abort mid-ADD: no result may surface
        a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #2 rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) saw_valid = 1'b1;
            tick();
        end
        check_output("abort_no_valid", 64'(saw_valid), 64'd0);
        apply_stimulus(32'd5, 32'd7, 1'b0, rs, rc, lat);
        check_output("after_abort_sum", 64'(rs), 64'hC);
        check_output("after_abort_carry", 64'(rc), 64'd0);
        check_output("after_abort_latency", 64'(lat), 64'(K));

        // K=1 build: result one cycle after accept
        k1_a = 8'hFF; k1_b = 8'hFF; k1_cin = 1'b1; k1_in_valid = 1'b1;
        tick();
        k1_in_valid = 1'b0;
        check_output("k1_not_yet_valid", 64'(k1_out_valid), 64'd0);
        tick();
        check_output("k1_valid", 64'(k1_out_valid), 64'd1);
        check_output("k1_sum", 64'(k1_sum), 64'hFF);
        check_output("k1_carry", 64'(k1_carry), 64'd1);
        k1_out_ready = 1'b1;
        tick();
        k1_out_ready = 1'b0;
        check_output("k1_release", 64'(k1_in_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
